// File: rtl/udp_tx_sched_pkg.sv
// Shared types and widths for the UDP TX deficit-round-robin scheduler.
// Imported by the interfaces and the scheduler top.
package udp_tx_sched_pkg;

  localparam int DEFICIT_WIDTH = 17;
  localparam int LENGTH_WIDTH  = 16;

  typedef enum logic [2:0] {
    SCAN,
    CREDIT,
    CHECK,
    HDR,
    PAYLOAD
  } sched_state_t;

endpackage

// File: rtl/udp_tx_sched_if.sv
// UDP TX header and AXI-stream payload handshake bundles.
// Each interface offers a sink-side and a source-side modport.
interface UDP_TX_HEADER_IF;
  import udp_tx_sched_pkg::*;

  logic                    hdr_valid;
  logic                    hdr_ready;
  logic [31:0]             ip_dest;
  logic [15:0]             src_port;
  logic [15:0]             dest_port;
  logic [LENGTH_WIDTH-1:0] length;
  logic [15:0]             checksum;

  modport Sink (
    input  hdr_valid, ip_dest, src_port,
    input  dest_port, length, checksum,
    output hdr_ready
  );

  modport Source (
    output hdr_valid, ip_dest, src_port,
    output dest_port, length, checksum,
    input  hdr_ready
  );
endinterface

interface AXIS_IF;
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
  logic [0:0] tkeep;
  logic       tlast;
  logic [7:0] tid;
  logic [7:0] tdest;
  logic [0:0] tuser;

  modport Receiver (
    input  tvalid, tdata, tkeep, tlast,
    input  tid, tdest, tuser,
    output tready
  );

  modport Transmitter (
    output tvalid, tdata, tkeep, tlast,
    output tid, tdest, tuser,
    input  tready
  );
endinterface

// File: rtl/udp_tx_drr_scheduler.sv
// DRR gate in front of the UDP TX mux: releases one requester at a time.
// Optional per-requester packet counters: UDP_TX_SCHED_STATS_EN.
module udp_tx_drr_scheduler
  import udp_tx_sched_pkg::*;
#(
  parameter int S_COUNT = 2,
  parameter int QUANTUM = 1500
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sched_enable,
  UDP_TX_HEADER_IF.Sink      udp_tx_header_if_sink    [S_COUNT],
  AXIS_IF.Receiver           udp_tx_payload_if_sink   [S_COUNT],
  UDP_TX_HEADER_IF.Source    udp_tx_header_if_source  [S_COUNT],
  AXIS_IF.Transmitter        udp_tx_payload_if_source [S_COUNT],
  output logic [S_COUNT-1:0] grant
`ifdef UDP_TX_SCHED_STATS_EN
  ,
  output logic [31:0]        pkt_count [S_COUNT]
`endif
);

  localparam int PTR_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(S_COUNT - 1);
  localparam logic [DEFICIT_WIDTH-1:0] QUANT = DEFICIT_WIDTH'(QUANTUM);

  sched_state_t state, state_nxt;

  logic [PTR_W-1:0]         ptr;
  logic [PTR_W-1:0]         ptr_inc;
  logic [DEFICIT_WIDTH-1:0] deficit [S_COUNT];

  logic [S_COUNT-1:0]      hv, hr, tv, tr, tl;
  logic [S_COUNT-1:0]      hdr_gnt, pay_gnt;
  logic [LENGTH_WIDTH-1:0] len [S_COUNT];

  logic                     cur_hv, cur_hr;
  logic                     cur_tv, cur_tr, cur_tl;
  logic [DEFICIT_WIDTH-1:0] cur_len, cur_def;
  logic                     fits, hdr_hs, last_hs;

  for (genvar i = 0; i < S_COUNT; i++) begin : g_gate
    assign hv[i]  = udp_tx_header_if_sink[i].hdr_valid;
    assign len[i] = udp_tx_header_if_sink[i].length;
    assign hr[i]  = udp_tx_header_if_source[i].hdr_ready;
    assign tv[i]  = udp_tx_payload_if_sink[i].tvalid;
    assign tl[i]  = udp_tx_payload_if_sink[i].tlast;
    assign tr[i]  = udp_tx_payload_if_source[i].tready;

    assign hdr_gnt[i] = (state == HDR) && (ptr == PTR_W'(i));
    assign pay_gnt[i] = (state == PAYLOAD) && (ptr == PTR_W'(i));
    assign grant[i]   = hdr_gnt[i] | pay_gnt[i];

    assign udp_tx_header_if_source[i].hdr_valid = hdr_gnt[i] & hv[i];
    assign udp_tx_header_if_sink[i].hdr_ready   = hdr_gnt[i] & hr[i];
    assign udp_tx_payload_if_source[i].tvalid   = pay_gnt[i] & tv[i];
    assign udp_tx_payload_if_sink[i].tready     = pay_gnt[i] & tr[i];

    assign udp_tx_header_if_source[i].ip_dest   = udp_tx_header_if_sink[i].ip_dest;
    assign udp_tx_header_if_source[i].src_port  = udp_tx_header_if_sink[i].src_port;
    assign udp_tx_header_if_source[i].dest_port = udp_tx_header_if_sink[i].dest_port;
    assign udp_tx_header_if_source[i].length    = len[i];
    assign udp_tx_header_if_source[i].checksum  = udp_tx_header_if_sink[i].checksum;

    assign udp_tx_payload_if_source[i].tdata = udp_tx_payload_if_sink[i].tdata;
    assign udp_tx_payload_if_source[i].tkeep = udp_tx_payload_if_sink[i].tkeep;
    assign udp_tx_payload_if_source[i].tlast = tl[i];
    assign udp_tx_payload_if_source[i].tid   = udp_tx_payload_if_sink[i].tid;
    assign udp_tx_payload_if_source[i].tdest = udp_tx_payload_if_sink[i].tdest;
    assign udp_tx_payload_if_source[i].tuser = udp_tx_payload_if_sink[i].tuser;
  end

  assign ptr_inc = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
  assign cur_hv  = hv[ptr];
  assign cur_hr  = hr[ptr];
  assign cur_tv  = tv[ptr];
  assign cur_tr  = tr[ptr];
  assign cur_tl  = tl[ptr];
  assign cur_len = {1'b0, len[ptr]};
  assign cur_def = deficit[ptr];
  assign fits    = cur_len <= cur_def;
  assign hdr_hs  = (state == HDR) && cur_hv && cur_hr;
  assign last_hs = (state == PAYLOAD) && cur_tv && cur_tr && cur_tl;

  always_comb begin
    state_nxt = state;
    unique case (state)
      SCAN:    if (sched_enable && cur_hv) state_nxt = CREDIT;
      CREDIT:  state_nxt = CHECK;
      CHECK:   state_nxt = (cur_hv && fits) ? HDR : SCAN;
      HDR:     if (hdr_hs) state_nxt = PAYLOAD;
      PAYLOAD: if (last_hs) state_nxt = sched_enable ? CHECK : SCAN;
      default: state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SCAN;
    else          state <= state_nxt;
  end

  // Unspent credit is kept only while the requester keeps a header waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
      for (int i = 0; i < S_COUNT; i++) deficit[i] <= '0;
    end else begin
      unique case (state)
        SCAN: if (sched_enable && !cur_hv) begin
          deficit[ptr] <= '0;
          ptr          <= ptr_inc;
        end
        CREDIT: deficit[ptr] <= cur_def + QUANT;
        CHECK: begin
          if (!cur_hv) begin
            deficit[ptr] <= '0;
            ptr          <= ptr_inc;
          end else if (!fits) begin
            ptr <= ptr_inc;
          end
        end
        HDR: if (hdr_hs) deficit[ptr] <= cur_def - cur_len;
        default: ;
      endcase
    end
  end

`ifdef UDP_TX_SCHED_STATS_EN
  for (genvar i = 0; i < S_COUNT; i++) begin : g_stats
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        pkt_count[i] <= '0;
      else if (pay_gnt[i] && tv[i] && tr[i] && tl[i])
        pkt_count[i] <= pkt_count[i] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_udp_tx_drr_scheduler.sv
// Scoreboard bench for udp_tx_drr_scheduler (S_COUNT=2, QUANTUM=1500).
// Stimulus queues expected header releases; a negedge monitor checks them.
module tb_udp_tx_drr_scheduler;

  localparam int S = 2;

  typedef struct {
    int req;
    int len;
    int gap;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sched_enable = 1'b1;

  always #5 clk = ~clk;

  logic [S-1:0] in_hv = '0;
  logic [S-1:0] in_tv = '0;
  logic [S-1:0] in_tl = '0;
  logic [15:0]  in_len [S];
  logic [S-1:0] snk_hr, snk_tr, src_hv, src_tv, src_tl;
  logic [15:0]  src_len [S];
  logic [S-1:0] grant;
`ifdef UDP_TX_SCHED_STATS_EN
  logic [31:0]  pkt_count [S];
`endif

  UDP_TX_HEADER_IF hin  [S] ();
  UDP_TX_HEADER_IF hout [S] ();
  AXIS_IF          pin  [S] ();
  AXIS_IF          pout [S] ();

  for (genvar i = 0; i < S; i++) begin : g_tie
    assign hin[i].hdr_valid = in_hv[i];
    assign hin[i].length    = in_len[i];
    assign hin[i].ip_dest   = 32'h0a000001 + i;
    assign hin[i].src_port  = 16'd1000 + 16'(i);
    assign hin[i].dest_port = 16'd2000;
    assign hin[i].checksum  = 16'd0;
    assign pin[i].tvalid    = in_tv[i];
    assign pin[i].tlast     = in_tl[i];
    assign pin[i].tdata     = 8'(i);
    assign pin[i].tkeep     = 1'b1;
    assign pin[i].tid       = 8'(i);
    assign pin[i].tdest     = 8'd0;
    assign pin[i].tuser     = 1'b0;
    assign hout[i].hdr_ready = 1'b1;
    assign pout[i].tready    = 1'b1;
    assign snk_hr[i]  = hin[i].hdr_ready;
    assign snk_tr[i]  = pin[i].tready;
    assign src_hv[i]  = hout[i].hdr_valid;
    assign src_len[i] = hout[i].length;
    assign src_tv[i]  = pout[i].tvalid;
    assign src_tl[i]  = pout[i].tlast;
  end

  udp_tx_drr_scheduler #(
    .S_COUNT(S),
    .QUANTUM(1500)
  ) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .sched_enable             (sched_enable),
    .udp_tx_header_if_sink    (hin),
    .udp_tx_payload_if_sink   (pin),
    .udp_tx_header_if_source  (hout),
    .udp_tx_payload_if_source (pout),
    .grant                    (grant)
`ifdef UDP_TX_SCHED_STATS_EN
    ,
    .pkt_count                (pkt_count)
`endif
  );

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q [$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every released header.
  int           cyc = 0;
  int           ref_cyc = 0;
  logic         rst_seen = 1'b1;
  logic         en_prev = 1'b1;
  logic [S-1:0] pay_open = '0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        rst_seen = 1'b1;
        pay_open = '0;
      end else begin
        if (rst_seen) ref_cyc = cyc;
        rst_seen = 1'b0;
        if (sched_enable && !en_prev) ref_cyc = cyc;
        for (int r = 0; r < S; r++) begin
          if (in_tv[r] && !pay_open[r])
            chk($sformatf("pay_gate%0d", r), int'(src_tv[r]), 0);
          if (src_hv[r]) begin
            if (exp_q.size() == 0) begin
              chk($sformatf("unexpected_hdr%0d", r), 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk("hdr_req", r, e.req);
              chk("hdr_len", int'(src_len[r]), e.len);
              chk("hdr_grant", int'(grant), 1 << r);
              if (e.gap > 0) chk("hdr_gap", cyc - ref_cyc, e.gap);
            end
            pay_open[r] = 1'b1;
          end
          if (src_tv[r] && src_tl[r]) begin
            pay_open[r] = 1'b0;
            ref_cyc = cyc;
          end
        end
      end
      en_prev = sched_enable;
    end
  end

  // Requester model: header and early payload, two beats per packet.
  int           pq [S][$];
  logic [S-1:0] active = '0;
  int           hook = 0;
  logic         fired = 1'b0;

  task automatic present();
    for (int r = 0; r < S; r++)
      if (!active[r] && pq[r].size() > 0) begin
        in_len[r] = 16'(pq[r].pop_front());
        in_hv[r]  = 1'b1;
        in_tv[r]  = 1'b1;
        in_tl[r]  = 1'b0;
        active[r] = 1'b1;
      end
  endtask

  task automatic step();
    logic [S-1:0] hhs, phs;
    @(negedge clk);
    hhs = in_hv & snk_hr;
    phs = in_tv & snk_tr;
    @(posedge clk);
    #1;
    for (int r = 0; r < S; r++) begin
      if (hhs[r]) in_hv[r] = 1'b0;
      if (phs[r]) begin
        if (in_tl[r]) begin
          in_tv[r]  = 1'b0;
          in_tl[r]  = 1'b0;
          active[r] = 1'b0;
        end else begin
          in_tl[r] = 1'b1;
          if (r == 0 && hook == 1) begin
            sched_enable = 1'b0;
            hook = 0;
          end
          if (r == 0 && hook == 2) begin
            fired = 1'b1;
            hook = 0;
          end
        end
      end
    end
    present();
  endtask

  function automatic bit drained();
    return pq[0].size() == 0 && pq[1].size() == 0 &&
           active == '0 && exp_q.size() == 0;
  endfunction

  task automatic run(input int budget);
    int n = 0;
    while (!drained() && n < budget) begin
      step();
      n++;
    end
    chk("drain", int'(drained()), 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_hv = '0;
    in_tv = '0;
    in_tl = '0;
    active = '0;
    for (int r = 0; r < S; r++) pq[r].delete();
    sched_enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    present();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic push(input int req, input int len, input int gap);
    exp_t e;
    e.req = req;
    e.len = len;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  initial begin
    int n;
    for (int r = 0; r < S; r++) in_len[r] = '0;

    // Two greedy requesters, 1000-byte packets.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      pq[0].push_back(1000);
      pq[1].push_back(1000);
    end
    present();
    #1;
    chk("rst_grant", int'(grant), 0);
    chk("rst_src_hv", int'(src_hv), 0);
    chk("rst_snk_hr", int'(snk_hr), 0);
    chk("rst_snk_tr", int'(snk_tr), 0);
    push(0, 1000, 3); push(1, 1000, 5);
    push(0, 1000, 5); push(0, 1000, 2);
    push(1, 1000, 5); push(1, 1000, 2);
    push(0, 1000, 5); push(1, 1000, 5);
    push(0, 1000, 5); push(0, 1000, 2);
    push(1, 1000, 5); push(1, 1000, 2);
    release_reset();
    run(400);

    // Oversized packet needs two visits; residual credit is zero after.
    do_reset();
    pq[0].push_back(3000);
    pq[0].push_back(1500);
    push(0, 3000, 7);
    push(0, 1500, 6);
    release_reset();
    run(200);

    // Lone requester 1, back-to-back 100-byte packets.
    do_reset();
    for (int k = 0; k < 5; k++) pq[1].push_back(100);
    push(1, 100, 4);
    for (int k = 0; k < 4; k++) push(1, 100, 2);
    release_reset();
    run(200);
`ifdef UDP_TX_SCHED_STATS_EN
    chk("pkt_count1", int'(pkt_count[1]), 5);
    chk("pkt_count0", int'(pkt_count[0]), 0);
`endif

    // Disable mid-payload: packet completes, then nothing is granted.
    do_reset();
    for (int k = 0; k < 3; k++) pq[0].push_back(1000);
    pq[1].push_back(1000);
    push(0, 1000, 3);
    hook = 1;
    release_reset();
    repeat (12) step();
    chk("dis_enable_dropped", int'(sched_enable), 0);
    repeat (10) step();
    chk("dis_grant", int'(grant), 0);
    chk("dis_sb_empty", exp_q.size(), 0);
    chk("dis_hdr_waiting", int'(in_hv[0]), 1);
    push(0, 1000, 3);
    push(0, 1000, 2);
    push(1, 1000, 5);
    sched_enable = 1'b1;
    run(200);

    // Reset pulse during payload aborts at once.
    do_reset();
    pq[0].push_back(1000);
    pq[1].push_back(1000);
    push(0, 1000, 3);
    hook = 2;
    fired = 1'b0;
    release_reset();
    n = 0;
    while (!fired && n < 30) begin
      step();
      n++;
    end
    chk("mid_fired", int'(fired), 1);
    chk("mid_grant_pre", int'(grant), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_grant", int'(grant), 0);
    chk("mid_src_hv", int'(src_hv), 0);
    chk("mid_src_tv", int'(src_tv), 0);
    chk("mid_snk_hr", int'(snk_hr), 0);
    chk("mid_snk_tr", int'(snk_tr), 0);
    do_reset();
    pq[0].push_back(1000);
    pq[1].push_back(1000);
    push(0, 1000, 3);
    push(1, 1000, 5);
    release_reset();
    run(200);

    chk("final_sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
